// File: rtl/hgcal_input_quantizer.sv
// ---------------------------------------------------------------------------
// hgcal_input_quantizer
//   Front end of the HGCAL autoencoder. It takes a serial stream of signed
//   sensor samples, quantizes each one to a Q_W-bit code against three signed
//   thresholds, and packs N_IN codes into one flat frame. Each packed frame is
//   handed to the layer0 LUT fabric over a valid/ready handshake.
//
//   A frame being collected can overlap a frame being presented, so at most
//   two frames are buffered: the collector and the output register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active low
//   s_valid    input sample valid
//   s_ready    block can accept a sample
//   s_data     signed input sample (IN_W bits)
//   s_last     sample is the last one of its frame
//   m_valid    packed frame valid
//   m_ready    layer0 side accepts the frame
//   m_data     packed codes; code i sits at [i*Q_W +: Q_W], i = arrival index
//   err_short  one-cycle pulse: a frame ended on s_last before N_IN samples
//   err_long   one-cycle pulse per beat dropped after an overlong frame
// ---------------------------------------------------------------------------
module hgcal_input_quantizer #(
  parameter int                     N_IN = 48,
  parameter int                     IN_W = 16,
  parameter int                     Q_W  = 2,
  parameter logic signed [IN_W-1:0] T0   = -16'sd64,
  parameter logic signed [IN_W-1:0] T1   = 16'sd0,
  parameter logic signed [IN_W-1:0] T2   = 16'sd64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_IN*Q_W-1:0]    m_data,
  output logic                   err_short,
  output logic                   err_long
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N_IN*Q_W-1:0]   coll_q, coll_d;
  logic                  drain_pend_q, drain_pend_d;
  logic [N_IN*Q_W-1:0]   m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  err_short_q, err_short_d;
  logic                  err_long_q, err_long_d;

  logic [Q_W-1:0]        code;
  logic [N_IN*Q_W-1:0]   frame_v;
  logic                  accept;
  logic                  out_free;
  logic                  overlong;

  // Ready is gated by rst_n so it is already low during the reset cycle and
  // comes up on the first cycle after release, when the state is FILL.
  assign s_ready   = rst_n && (state_q != HOLD);
  assign accept    = s_valid && s_ready;
  assign out_free  = !m_valid_q || m_ready;

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

  // Four-level signed quantizer on the incoming sample.
  always_comb begin
    if (s_data < T0)      code = Q_W'(0);
    else if (s_data < T1) code = Q_W'(1);
    else if (s_data < T2) code = Q_W'(2);
    else                  code = Q_W'(3);
  end

  // Collector contents as they would look with the current beat written in.
  // On s_last every slot above the current one is cleared, so a short frame
  // never carries stale codes from the previous frame.
  always_comb begin
    frame_v = coll_q;
    for (int i = 0; i < N_IN; i++) begin
      if (i == int'(idx_q))
        frame_v[i*Q_W +: Q_W] = code;
      else if (s_last && (i > int'(idx_q)))
        frame_v[i*Q_W +: Q_W] = '0;
    end
  end

  // Next-state logic. A frame that fills all N_IN slots without s_last is
  // still delivered, but the state machine then drains the remaining beats
  // of that oversized frame; drain_pend remembers this across a HOLD stall.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    coll_d       = coll_q;
    drain_pend_d = drain_pend_q;
    m_valid_d    = m_valid_q && !m_ready;
    m_data_d     = m_data_q;
    err_short_d  = 1'b0;
    err_long_d   = 1'b0;
    overlong     = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (s_last || (idx_q == LAST_IDX)) begin
            idx_d       = '0;
            err_short_d = s_last && (idx_q != LAST_IDX);
            overlong    = !s_last;
            if (out_free) begin
              m_data_d  = frame_v;
              m_valid_d = 1'b1;
              state_d   = overlong ? DRAIN : FILL;
            end else begin
              coll_d       = frame_v;
              drain_pend_d = overlong;
              state_d      = HOLD;
            end
          end else begin
            coll_d = frame_v;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end

      HOLD: begin
        if (out_free) begin
          m_data_d     = coll_q;
          m_valid_d    = 1'b1;
          state_d      = drain_pend_q ? DRAIN : FILL;
          drain_pend_d = 1'b0;
        end
      end

      DRAIN: begin
        if (accept) begin
          err_long_d = 1'b1;
          if (s_last) state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      idx_q        <= '0;
      coll_q       <= '0;
      drain_pend_q <= 1'b0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coll_q       <= coll_d;
      drain_pend_q <= drain_pend_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// ---------------------------------------------------------------------------
// tb_hgcal_input_quantizer
//   Directed bench for hgcal_input_quantizer with N_IN=4 and thresholds
//   -64 / 0 / 64, followed by a random-handshake run against a reference
//   quantizer and a frame scoreboard.
// ---------------------------------------------------------------------------
module tb_hgcal_input_quantizer;

  localparam int N_IN = 4;
  localparam int IN_W = 16;
  localparam int Q_W  = 2;

  logic                   clk;
  logic                   rst_n;
  logic                   s_valid;
  logic                   s_ready;
  logic signed [IN_W-1:0] s_data;
  logic                   s_last;
  logic                   m_valid;
  logic                   m_ready;
  logic [N_IN*Q_W-1:0]    m_data;
  logic                   err_short;
  logic                   err_long;

  int checks = 0;
  int errors = 0;

  hgcal_input_quantizer #(
    .N_IN(N_IN),
    .IN_W(IN_W),
    .Q_W (Q_W),
    .T0  (-16'sd64),
    .T1  (16'sd0),
    .T2  (16'sd64)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .err_short(err_short),
    .err_long (err_long)
  );

  // 100 MHz free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference quantizer for the -64 / 0 / 64 thresholds.
  function automatic logic [1:0] refCode(input int x);
    if (x < -64)     return 2'd0;
    else if (x < 0)  return 2'd1;
    else if (x < 64) return 2'd2;
    else             return 2'd3;
  endfunction

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample and hold it until it is accepted (bounded wait).
  task automatic applyStimulus(input logic signed [IN_W-1:0] d, input logic last);
    int n;
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) checkOutput("beat_timeout", 64'(s_ready), 64'(1));
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  logic [7:0] expq[$];
  logic [7:0] build;
  logic [7:0] expFrame;
  int fi, bi, recvd, cur;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;

    // Power-on reset.
    step();
    step();
    checkOutput("rst_s_ready",   64'(s_ready),   64'(0));
    checkOutput("rst_m_valid",   64'(m_valid),   64'(0));
    checkOutput("rst_m_data",    64'(m_data),    64'(0));
    checkOutput("rst_err_short", 64'(err_short), 64'(0));
    checkOutput("rst_err_long",  64'(err_long),  64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("rel_s_ready", 64'(s_ready), 64'(1));

    // Reset in the middle of a frame discards the partial frame.
    applyStimulus(16'sd100, 1'b0);
    applyStimulus(16'sd100, 1'b0);
    rst_n = 1'b0;
    step();
    checkOutput("mid_rst_s_ready", 64'(s_ready), 64'(0));
    step();
    checkOutput("mid_rst_m_valid", 64'(m_valid), 64'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rel_s_ready", 64'(s_ready), 64'(1));
    applyStimulus(16'sd63, 1'b0);
    applyStimulus(16'sd63, 1'b0);
    applyStimulus(16'sd63, 1'b0);
    applyStimulus(16'sd63, 1'b1);
    checkOutput("restart_m_valid", 64'(m_valid), 64'(1));
    checkOutput("restart_m_data",  64'(m_data),  64'h0AA);

    // Quantizer boundaries: codes 00,01,10,11.
    applyStimulus(-16'sd100, 1'b0);
    applyStimulus(-16'sd64,  1'b0);
    applyStimulus(16'sd63,   1'b0);
    applyStimulus(16'sd64,   1'b1);
    checkOutput("quant_m_valid",   64'(m_valid),   64'(1));
    checkOutput("quant_m_data",    64'(m_data),    64'h0E4);
    checkOutput("quant_err_short", 64'(err_short), 64'(0));
    step();
    checkOutput("quant_m_valid_clr", 64'(m_valid), 64'(0));

    // Backpressure: second frame stalls in HOLD until the first drains.
    m_ready = 1'b0;
    applyStimulus(16'sd100,  1'b0);
    applyStimulus(-16'sd100, 1'b0);
    applyStimulus(16'sd0,    1'b0);
    applyStimulus(-16'sd1,   1'b1);
    checkOutput("bp_a_valid", 64'(m_valid), 64'(1));
    checkOutput("bp_a_data",  64'(m_data),  64'h063);
    applyStimulus(-16'sd65, 1'b0);
    applyStimulus(-16'sd64, 1'b0);
    applyStimulus(-16'sd1,  1'b0);
    applyStimulus(16'sd65,  1'b1);
    checkOutput("bp_hold_s_ready", 64'(s_ready), 64'(0));
    checkOutput("bp_hold_data",    64'(m_data),  64'h063);
    step();
    step();
    checkOutput("bp_stall_data",  64'(m_data),  64'h063);
    checkOutput("bp_stall_valid", 64'(m_valid), 64'(1));
    m_ready = 1'b1;
    step();
    checkOutput("bp_b_valid",   64'(m_valid), 64'(1));
    checkOutput("bp_b_data",    64'(m_data),  64'h0D4);
    checkOutput("bp_b_s_ready", 64'(s_ready), 64'(1));
    step();
    checkOutput("bp_b_clr", 64'(m_valid), 64'(0));

    // Short frame: missing slot is zero, err_short pulses once.
    applyStimulus(16'sd100, 1'b0);
    applyStimulus(16'sd100, 1'b0);
    applyStimulus(16'sd100, 1'b1);
    checkOutput("short_err",   64'(err_short), 64'(1));
    checkOutput("short_valid", 64'(m_valid),   64'(1));
    checkOutput("short_data",  64'(m_data),    64'h03F);
    step();
    checkOutput("short_err_clr", 64'(err_short), 64'(0));

    // Long frame: first four codes delivered, beats 5 and 6 dropped.
    applyStimulus(16'sd100,  1'b0);
    applyStimulus(16'sd10,   1'b0);
    applyStimulus(-16'sd10,  1'b0);
    applyStimulus(-16'sd100, 1'b0);
    checkOutput("long_valid", 64'(m_valid),  64'(1));
    checkOutput("long_data",  64'(m_data),   64'h01B);
    checkOutput("long_err0",  64'(err_long), 64'(0));
    applyStimulus(16'sd5, 1'b0);
    checkOutput("long_err5",   64'(err_long), 64'(1));
    checkOutput("long_valid5", 64'(m_valid),  64'(0));
    applyStimulus(16'sd7, 1'b1);
    checkOutput("long_err6", 64'(err_long), 64'(1));
    step();
    checkOutput("long_err_clr", 64'(err_long), 64'(0));
    checkOutput("long_no_frame", 64'(m_valid), 64'(0));
    applyStimulus(-16'sd100, 1'b0);
    applyStimulus(-16'sd64,  1'b0);
    applyStimulus(16'sd63,   1'b0);
    applyStimulus(16'sd64,   1'b1);
    checkOutput("after_long_data", 64'(m_data), 64'h0E4);
    step();

    // Random handshakes on both sides against the reference scoreboard.
    fi = 0;
    bi = 0;
    recvd = 0;
    build = '0;
    cur = int'($urandom_range(0, 400)) - 200;
    for (int cyc = 0; cyc < 60000 && recvd < 1000; cyc++) begin
      s_valid = (fi < 1000) && 1'($urandom_range(0, 1));
      s_data  = 16'(cur);
      s_last  = (bi == 3);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (s_valid && s_ready) begin
        build[bi*2 +: 2] = refCode(cur);
        if (bi == 3) begin
          expq.push_back(build);
          bi = 0;
          fi++;
        end else begin
          bi++;
        end
        cur = int'($urandom_range(0, 400)) - 200;
      end
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checkOutput("rand_extra", 64'(expq.size()), 64'(1));
        end else begin
          expFrame = expq.pop_front();
          checkOutput("rand_frame", 64'(m_data), 64'(expFrame));
        end
        recvd++;
      end
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checkOutput("rand_count", 64'(recvd), 64'(1000));
    checkOutput("rand_left",  64'(expq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
